instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32I instruction encoder and loader, the counterpart to the single-cycle control unit's decode path. It accepts symbolic instruction requests (operation, register indices, signed immediate) over a valid/ready handshake and packs each one into a 32-bit RV32I word. It covers exactly the subset the control unit decodes. Each word is written into instruction memory at an auto-incrementing byte address, so benches and boot logic can build programs without a hand assembler.

## Interface
- ADDR_W, 32, width of instruction-memory byte address.
- BASE_ADDR, 0, first write address after reset; must be a multiple of 4.

- clk  in  1  clock, all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept.
- req_op  in  4  0 ADD, 1 SUB, 2 XOR, 3 AND, 4 ADDI, 5 BEQ, 6 BNE, 7 JAL, 8 JALR; 9–15 illegal.
- req_rd, req_rs1, req_rs2  in  5 each  register indices; unused fields are ignored.
- req_imm  in  32  signed byte immediate/offset.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  byte address of the current word.
- mem_wdata  out  32  encoded instruction.
- err  out  1  one-cycle pulse; request rejected, nothing written.
- wrapped  out  1  sticky; address pointer has wrapped.

## Operation
- FSM states are IDLE, ENCODE and WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture all req_* fields and go to ENCODE.
- ENCODE:
  - req_ready=0.
  - Build the word into a register.
  - If the op is illegal (or out of range, see Configuration): pulse err, return to IDLE, pointer unchanged.
  - Otherwise go to WRITE.
- WRITE:
  - mem_we=1, mem_addr=ptr, mem_wdata=word.
  - ptr<=ptr+4 (mod 2^ADDR_W).
  - If ptr+4 wraps to 0, set wrapped.
  - Return to IDLE.
- Encodings:
  - R-type: {funct7,rs2,rs1,funct3,rd,0110011}. ADD is f3=000, f7=0000000. SUB is f3=000, f7=0100000. XOR is f3=100. AND is f3=111.
  - ADDI: {imm[11:0],rs1,000,rd,0010011}.
  - BEQ/BNE: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}, with f3=000 for BEQ and 001 for BNE.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
  - JALR: {imm[11:0],rs1,000,rd,1100111}.
- Immediate bits not listed in an encoding are discarded.
- Outputs when not in WRITE: mem_we=0. mem_addr and mem_wdata hold their last values.

## Timing
- Reset values: state=IDLE, ptr=BASE_ADDR, word=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, wrapped=0. req_ready=0 while rst is high, 1 afterwards.
- Acceptance at edge N:
  - ENCODE occupies cycle N+1.
  - Either mem_we is high during cycle N+2, or err is high during cycle N+2.
  - Accepting the next request is possible at edge N+3.
- Throughput is one request per 3 cycles; req_ready is low in ENCODE and WRITE.
- Requesters hold req_* stable while req_valid&&!req_ready. Fields are sampled only on the accept edge.
- err and mem_we are mutually exclusive and never high for more than one cycle.
- Reset mid-operation (ENCODE or WRITE) aborts immediately:
  - No write strobe is emitted.
  - ptr returns to BASE_ADDR and wrapped clears.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN, when defined: ENCODE rejects out-of-range immediates with err and no write.
  - ADDI/JALR: imm must be in −2048..2047.
  - BEQ/BNE: imm must be even and in −4096..4094.
  - JAL: imm must be even and in −1048576..1048574.
- Without the macro, there is no range check: immediates are silently truncated per the encodings, and bit 0 of branch/jump offsets is dropped.

## Test plan
- Reset, then ADDI rd=1 rs1=0 imm=5 -> mem_we at cycle N+2, addr=0x0, wdata=0x00500093. Next request is written to addr=0x4.
- ADD rd=3 rs1=1 rs2=2, then SUB with the same fields -> 0x002081B3 at 0x0, 0x402081B3 at 0x4.
- BEQ rs1=1 rs2=2 imm=8 -> 0x00208463. BNE with the same fields -> 0x00209463. JAL rd=1 imm=16 -> 0x010000EF.
- req_op=15 -> err pulse at N+2, no mem_we. The following ADDI still lands at the unchanged ptr.
- ADDI rd=1 rs1=0 imm=4096:
  - With INSTR_ENC_RANGE_CHECK_EN: err, no write.
  - Without it: wdata=0x00000093.
- ADDR_W=4, BASE_ADDR=0xC, one request -> written at 0xC, ptr wraps to 0x0, wrapped=1. Assert rst while in ENCODE -> no mem_we, ptr=0xC, wrapped=0.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Sequential RV32I instruction encoder/loader. Accepts one symbolic request
// (op, rd, rs1, rs2, imm) per valid/ready handshake, packs it into a 32-bit
// RV32I word and writes it to instruction memory at an auto-incrementing
// byte address. Covers ADD, SUB, XOR, AND, ADDI, BEQ, BNE, JAL, JALR.
//
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN
//   When defined, out-of-range or misaligned immediates are rejected with err.
//   When undefined, immediates are silently truncated per the encodings.
//
// Parameters:
//   ADDR_W    - instruction-memory byte address width
//   BASE_ADDR - first write address after reset (multiple of 4)
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid / req_ready - request handshake
//   req_op                - 0 ADD,1 SUB,2 XOR,3 AND,4 ADDI,5 BEQ,6 BNE,7 JAL,8 JALR
//   req_rd/rs1/rs2        - register indices
//   req_imm               - signed byte immediate/offset
//   mem_we                - one-cycle write strobe
//   mem_addr, mem_wdata   - write address / encoded word (held between writes)
//   err                   - one-cycle pulse, request rejected
//   wrapped               - sticky, address pointer wrapped to 0
// -----------------------------------------------------------------------------
module instr_encoder #(
   parameter int unsigned           ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [31:0]       req_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              err,
   output logic              wrapped
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ENCODE = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_ADDI = 4'd4;
   localparam logic [3:0] OP_BEQ  = 4'd5;
   localparam logic [3:0] OP_BNE  = 4'd6;
   localparam logic [3:0] OP_JAL  = 4'd7;
   localparam logic [3:0] OP_JALR = 4'd8;

   logic [1:0]        state_q, state_d;
   logic [3:0]        op_q;
   logic [4:0]        rd_q, rs1_q, rs2_q;
   logic [31:0]       imm_q;
   logic [31:0]       word_q, word_d;
   logic              legal_d;
   logic [ADDR_W-1:0] ptr_q, ptr_inc;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_we_q, err_q, wrapped_q;

   assign ptr_inc = ptr_q + ADDR_W'(4);

   // Encoder operates on the captured fields, so req_* may change freely
   // after the accept edge.
   always_comb begin
      word_d  = '0;
      legal_d = 1'b1;
      unique case (op_q)
         OP_ADD:  word_d = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
         OP_SUB:  word_d = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
         OP_XOR:  word_d = {7'b0000000, rs2_q, rs1_q, 3'b100, rd_q, 7'b0110011};
         OP_AND:  word_d = {7'b0000000, rs2_q, rs1_q, 3'b111, rd_q, 7'b0110011};
         OP_ADDI: word_d = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
         OP_BEQ:  word_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                            imm_q[4:1], imm_q[11], 7'b1100011};
         OP_BNE:  word_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b001,
                            imm_q[4:1], imm_q[11], 7'b1100011};
         OP_JAL:  word_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                            rd_q, 7'b1101111};
         OP_JALR: word_d = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b1100111};
         default: legal_d = 1'b0;
      endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
      // A value fits an N-bit signed field when all bits from N-1 upward
      // are copies of the sign.
      case (op_q)
         OP_ADDI, OP_JALR:
            if (!((&imm_q[31:11]) || (~|imm_q[31:11]))) legal_d = 1'b0;
         OP_BEQ, OP_BNE:
            if (imm_q[0] || !((&imm_q[31:12]) || (~|imm_q[31:12]))) legal_d = 1'b0;
         OP_JAL:
            if (imm_q[0] || !((&imm_q[31:20]) || (~|imm_q[31:20]))) legal_d = 1'b0;
         default: ;
      endcase
`endif
   end

`ifndef INSTR_ENC_RANGE_CHECK_EN
   // Without range checking these immediate bits are intentionally dropped.
   logic unused_imm;
   assign unused_imm = ^{imm_q[31:21], imm_q[0]};
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (req_valid) state_d = S_ENCODE;
         S_ENCODE: state_d = legal_d ? S_WRITE : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         imm_q      <= '0;
         word_q     <= '0;
         ptr_q      <= BASE_ADDR;
         mem_addr_q <= BASE_ADDR;
         mem_we_q   <= 1'b0;
         err_q      <= 1'b0;
         wrapped_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_we_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q  <= req_op;
                  rd_q  <= req_rd;
                  rs1_q <= req_rs1;
                  rs2_q <= req_rs2;
                  imm_q <= req_imm;
               end
            end
            S_ENCODE: begin
               // Strobe and address are registered here so they are
               // valid for exactly the WRITE cycle.
               if (legal_d) begin
                  word_q     <= word_d;
                  mem_addr_q <= ptr_q;
                  mem_we_q   <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
            end
            S_WRITE: begin
               ptr_q <= ptr_inc;
               if (ptr_inc == '0) wrapped_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (state_q == S_IDLE) && !rst;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = word_q;
   assign err       = err_q;
   assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder. Two instances: a default 32-bit
// one for directed and random traffic, and a 4-bit-address one starting at
// 0xC for pointer wrap and mid-operation reset. Expected words come from an
// arithmetic reference encoder; pointer/wrap state is tracked in the bench.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        a_rst, b_rst;
   logic        a_valid, b_valid;
   logic [3:0]  op;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;

   logic        a_ready, a_we, a_err, a_wrapped;
   logic [31:0] a_addr, a_wdata;
   logic        b_ready, b_we, b_err, b_wrapped;
   logic [3:0]  b_addr;
   logic [31:0] b_wdata;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) u_a (
      .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
      .req_op(op), .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2), .req_imm(imm),
      .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .err(a_err), .wrapped(a_wrapped));

   instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) u_b (
      .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
      .req_op(op), .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2), .req_imm(imm),
      .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .err(b_err), .wrapped(b_wrapped));

   // Selected-instance view used by the transaction task.
   bit          use_b;
   logic        s_ready, s_we, s_err, s_wrapped;
   logic [31:0] s_addr, s_wdata;
   assign s_ready   = use_b ? b_ready   : a_ready;
   assign s_we      = use_b ? b_we      : a_we;
   assign s_err     = use_b ? b_err     : a_err;
   assign s_wrapped = use_b ? b_wrapped : a_wrapped;
   assign s_addr    = use_b ? {28'd0, b_addr} : a_addr;
   assign s_wdata   = use_b ? b_wdata   : a_wdata;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] ptr_m  [2];
   logic        wrap_m [2];
   logic [31:0] mask_m [2];
   logic [31:0] base_m [2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference encoder: fields placed with shifts/masks straight from the
   // RV32I formats; legality and range checks use signed arithmetic.
   function automatic void ref_enc(input logic [3:0] o, input logic [4:0] d,
                                   input logic [4:0] s1, input logic [4:0] s2,
                                   input logic [31:0] im, output bit ok,
                                   output logic [31:0] w);
      logic [31:0] rdv = 32'(d);
      logic [31:0] r1  = 32'(s1);
      logic [31:0] r2  = 32'(s2);
      longint      si  = longint'($signed(im));
      ok = 1'b1;
      w  = '0;
      case (o)
         4'd0: w = (r2 << 20) | (r1 << 15) | (rdv << 7) | 32'h33;
         4'd1: w = (32'h20 << 25) | (r2 << 20) | (r1 << 15) | (rdv << 7) | 32'h33;
         4'd2: w = (r2 << 20) | (r1 << 15) | (32'd4 << 12) | (rdv << 7) | 32'h33;
         4'd3: w = (r2 << 20) | (r1 << 15) | (32'd7 << 12) | (rdv << 7) | 32'h33;
         4'd4: w = ((im & 32'hFFF) << 20) | (r1 << 15) | (rdv << 7) | 32'h13;
         4'd5, 4'd6:
            w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) |
                (r2 << 20) | (r1 << 15) | ((o == 4'd6 ? 32'd1 : 32'd0) << 12) |
                (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7) | 32'h63;
         4'd7:
            w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
                (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'hFF) << 12) |
                (rdv << 7) | 32'h6F;
         4'd8: w = ((im & 32'hFFF) << 20) | (r1 << 15) | (rdv << 7) | 32'h67;
         default: ok = 1'b0;
      endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
      if ((o == 4'd4 || o == 4'd8) && (si < -2048 || si > 2047)) ok = 1'b0;
      if ((o == 4'd5 || o == 4'd6) &&
          ((im & 32'd1) != 0 || si < -4096 || si > 4094)) ok = 1'b0;
      if (o == 4'd7 && ((im & 32'd1) != 0 || si < -1048576 || si > 1048574)) ok = 1'b0;
`else
      if (si == 0) ok = ok;
`endif
   endfunction

   // One full transaction: accept at edge N, check ENCODE cycle (N+1),
   // write/err cycle (N+2) and the quiet cycle after (N+3).
   task automatic send(input bit sel, input logic [3:0] o, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
      bit          ok;
      logic [31:0] w;
      int          t = 0;
      int          i = sel ? 1 : 0;
      logic [31:0] nxt;
      ref_enc(o, d, s1, s2, im, ok, w);
      use_b = sel;
      @(negedge clk);
      while (!s_ready && t < 20) begin @(negedge clk); t++; end
      if (!s_ready) begin chk("ready_timeout", 64'(s_ready), 64'd1); return; end
      op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
      if (sel) b_valid = 1'b1; else a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid = 1'b0; b_valid = 1'b0;
      op = $urandom(); imm = $urandom();
      @(negedge clk);
      chk("enc_we",    64'(s_we),    64'd0);
      chk("enc_err",   64'(s_err),   64'd0);
      chk("enc_ready", 64'(s_ready), 64'd0);
      @(negedge clk);
      if (ok) begin
         chk("wr_we",    64'(s_we),    64'd1);
         chk("wr_err",   64'(s_err),   64'd0);
         chk("wr_addr",  64'(s_addr),  64'(ptr_m[i]));
         chk("wr_wdata", 64'(s_wdata), 64'(w));
      end else begin
         chk("rej_err", 64'(s_err), 64'd1);
         chk("rej_we",  64'(s_we),  64'd0);
      end
      @(negedge clk);
      chk("post_we",  64'(s_we),  64'd0);
      chk("post_err", 64'(s_err), 64'd0);
      if (ok) begin
         chk("post_addr_hold", 64'(s_addr), 64'(ptr_m[i]));
         nxt = (ptr_m[i] + 32'd4) & mask_m[i];
         if (nxt == 0) wrap_m[i] = 1'b1;
         ptr_m[i] = nxt;
      end
      chk("wrapped", 64'(s_wrapped), 64'(wrap_m[i]));
   endtask

   function automatic logic [31:0] pick_imm();
      logic [31:0] edges [12];
      edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
                -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, 32'd3, -32'sd1048576};
      case ($urandom_range(0, 3))
         0:       return $urandom();
         1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
         2:       return edges[$urandom_range(0, 11)];
         default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
   endfunction

   initial begin
      a_rst = 1'b1; b_rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; use_b = 1'b0;
      op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      base_m = '{32'h0, 32'hC};
      mask_m = '{32'hFFFF_FFFF, 32'hF};
      ptr_m  = base_m;
      wrap_m = '{1'b0, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst_ready",   64'(a_ready),   64'd0);
      chk("rst_we",      64'(a_we),      64'd0);
      chk("rst_err",     64'(a_err),     64'd0);
      chk("rst_addr",    64'(a_addr),    64'd0);
      chk("rst_wdata",   64'(a_wdata),   64'd0);
      chk("rst_wrapped", 64'(a_wrapped), 64'd0);
      chk("rst_b_addr",  64'(b_addr),    64'hC);
      a_rst = 1'b0; b_rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(a_ready), 64'd1);

      // Directed cases
      send(0, 4'd4, 5'd1, 5'd0, 5'd0, 32'd5);     // ADDI x1,x0,5
      send(0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0);     // ADD
      send(0, 4'd1, 5'd3, 5'd1, 5'd2, 32'd0);     // SUB
      send(0, 4'd5, 5'd0, 5'd1, 5'd2, 32'd8);     // BEQ
      send(0, 4'd6, 5'd0, 5'd1, 5'd2, 32'd8);     // BNE
      send(0, 4'd7, 5'd1, 5'd0, 5'd0, 32'd16);    // JAL
      send(0, 4'd15, 5'd1, 5'd2, 5'd3, 32'd1);    // illegal op
      send(0, 4'd4, 5'd1, 5'd0, 5'd0, 32'd7);     // lands at unchanged ptr
      send(0, 4'd4, 5'd1, 5'd0, 5'd0, 32'd4096);  // out of 12-bit range
      send(0, 4'd8, 5'd5, 5'd6, 5'd0, -32'sd2048);
      send(0, 4'd7, 5'd2, 5'd0, 5'd0, -32'sd1048576);
      send(0, 4'd5, 5'd0, 5'd3, 5'd4, 32'd7);     // odd branch offset

      // Randomized traffic
      for (int k = 0; k < 60; k++)
         send(0, 4'($urandom_range(0, 15)), 5'($urandom()), 5'($urandom()),
              5'($urandom()), pick_imm());

      // Narrow instance: write at 0xC wraps the pointer to 0
      send(1, 4'd4, 5'd1, 5'd0, 5'd0, 32'd5);
      send(1, 4'd2, 5'd7, 5'd8, 5'd9, 32'd0);

      // Reset during ENCODE aborts the write and restores base/wrapped
      use_b = 1'b1;
      @(negedge clk);
      op = 4'd0; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; b_valid = 1'b1;
      @(posedge clk);
      #1 b_valid = 1'b0;
      @(negedge clk);
      b_rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_we",      64'(b_we),      64'd0);
      chk("mid_rst_err",     64'(b_err),     64'd0);
      chk("mid_rst_wrapped", 64'(b_wrapped), 64'd0);
      chk("mid_rst_addr",    64'(b_addr),    64'hC);
      chk("mid_rst_ready",   64'(b_ready),   64'd0);
      @(negedge clk);
      chk("mid_rst_no_we",   64'(b_we),      64'd0);
      b_rst = 1'b0;
      ptr_m[1] = 32'hC; wrap_m[1] = 1'b0;
      send(1, 4'd3, 5'd4, 5'd5, 5'd6, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
